// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder on the processor dmem port.
// Combines a word RAM, a memory-mapped TX FIFO with status register,
// and a free-running 32-bit cycle counter. Reads are combinational so
// the M-stage result is ready before the edge that loads the MW latch.
module dmem_responder #(
  parameter int RAM_AW     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [31:0] ADDR_STATUS = 32'h0000_F000;
  localparam logic [31:0] ADDR_TXDATA = 32'h0000_F001;
  localparam logic [31:0] ADDR_CYCLES = 32'h0000_F002;

  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  // Storage and state
  logic [31:0]   ram [0:(1<<RAM_AW)-1];
  logic [31:0]   fifo_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   cycles;

  // Address decode
  logic sel_ram;
  logic sel_status;
  logic sel_tx;
  logic sel_cycles;

  assign sel_ram    = (address_dmem[31:RAM_AW] == '0);
  assign sel_status = (address_dmem == ADDR_STATUS);
  assign sel_tx     = (address_dmem == ADDR_TXDATA);
  assign sel_cycles = (address_dmem == ADDR_CYCLES);

  // FIFO flags and transfer qualifiers
  logic fifo_full;
  logic fifo_empty;
  logic push_req;
  logic pop;
  logic push_ok;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);

  // Handshake: the consumer takes the head entry at a rising edge where
  // out_valid and out_ready are both high. out_valid/out_data derive only
  // from registered FIFO state, so they move only on edges or reset, and
  // out_ready never combinationally affects them (no fall-through).
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? 32'h0 : fifo_mem[head];

  assign pop      = out_valid && out_ready;
  assign push_req = wren && sel_tx;
  // A full FIFO can still accept a push when the head leaves on the same edge.
  assign push_ok  = push_req && (!fifo_full || pop);

  // Status word: {26'b0, count[2:0], overflow, empty, full}
  logic [31:0] status_word;
  assign status_word = {{(32-CW-3){1'b0}}, count, overflow, fifo_empty, fifo_full};

  // Read-data mux; unmapped addresses and TXDATA read as zero
  always_comb begin
    q_dmem = 32'h0;
    if (sel_ram) begin
      q_dmem = ram[address_dmem[RAM_AW-1:0]];
    end else if (sel_status) begin
      q_dmem = status_word;
    end else if (sel_cycles) begin
      q_dmem = cycles;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clock) begin
    if (wren && sel_ram) begin
      ram[address_dmem[RAM_AW-1:0]] <= data;
    end
  end

  // FIFO entry storage; only entries between head and tail are meaningful
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_mem[tail] <= data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      if (push_ok && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push_ok) begin
        count <= count - CNT_ONE;
      end
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end else if (wren && sel_status) begin
        overflow <= 1'b0;
      end
    end
  end

  // Free-running cycle counter; a CYCLES write replaces the increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycles <= 32'h0;
    end else if (wren && sel_cycles) begin
      cycles <= data;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: RAM, TX FIFO, status and counter.
module tb_dmem_responder;

  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];
  logic [31:0] rd_val;

  localparam logic [31:0] A_STATUS = 32'h0000_F000;
  localparam logic [31:0] A_TX     = 32'h0000_F001;
  localparam logic [31:0] A_CYC    = 32'h0000_F002;

  dmem_responder #(.RAM_AW(12), .FIFO_DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks: called mid-cycle, writes complete at the next rising edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address_dmem = a;
    data         = d;
    wren         = 1'b1;
    @(posedge clock);
    #1;
    wren = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    address_dmem = a;
    wren         = 1'b0;
    #1;
    v = q_dmem;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pops expected entries one per cycle with out_ready held high
  task automatic drain_check(input string tag);
    logic [31:0] e;
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_data"}, out_data, e);
      tick();
    end
    out_ready = 1'b0;
    check({tag, "_valid_after"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_data_after"}, out_data, 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    address_dmem = 32'h0;
    data = 32'h0;
    wren = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'h0);
    rd(A_STATUS, rd_val); check("rst_status", rd_val, 32'h2);
    rd(A_CYC, rd_val);    check("rst_cycles", rd_val, 32'h0);

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Counter: N edges after release reads N
    rd(A_CYC, rd_val); check("cyc_0", rd_val, 32'd0);
    repeat (10) @(posedge clock);
    #1;
    rd(A_CYC, rd_val); check("cyc_10", rd_val, 32'd10);

    // RAM
    wr(32'd5, 32'hDEAD_BEEF);
    wr(32'd4095, 32'h1234_5678);
    rd(32'd5, rd_val);       check("ram_5", rd_val, 32'hDEAD_BEEF);
    rd(32'd4095, rd_val);    check("ram_4095", rd_val, 32'h1234_5678);
    rd(32'h1000, rd_val);    check("ram_oob", rd_val, 32'h0);
    rd(32'hF003, rd_val);    check("unmapped", rd_val, 32'h0);
    rd(A_TX, rd_val);        check("tx_read", rd_val, 32'h0);

    // Same-cycle read/write returns old data
    wr(32'd6, 32'h1111_1111);
    address_dmem = 32'd6;
    data = 32'h2222_2222;
    wren = 1'b1;
    #1;
    check("rw_old", q_dmem, 32'h1111_1111);
    tick();
    wren = 1'b0;
    rd(32'd6, rd_val); check("rw_new", rd_val, 32'h2222_2222);

    // FIFO fill and overflow
    wr(A_TX, 32'd1);
    check("push1_valid", {31'b0, out_valid}, 32'd1);
    check("push1_data", out_data, 32'd1);
    rd(A_STATUS, rd_val); check("status_c1", rd_val, 32'h08);
    for (int i = 2; i <= 5; i++) wr(A_TX, i);
    rd(A_STATUS, rd_val); check("status_ovf", rd_val, 32'h25);
    check("full_head", out_data, 32'd1);
    wr(A_STATUS, 32'hFFFF_FFFF);
    rd(A_STATUS, rd_val); check("status_clr", rd_val, 32'h21);

    // Drain from full
    for (int i = 1; i <= 4; i++) exp_q.push_back(i);
    drain_check("drain");
    rd(A_STATUS, rd_val); check("status_empty", rd_val, 32'h02);

    // Full with simultaneous push and pop
    for (int i = 5; i <= 8; i++) wr(A_TX, i);
    address_dmem = A_TX;
    data = 32'd9;
    wren = 1'b1;
    out_ready = 1'b1;
    #1;
    check("pp_head", out_data, 32'd5);
    tick();
    wren = 1'b0;
    out_ready = 1'b0;
    rd(A_STATUS, rd_val); check("pp_status", rd_val, 32'h21);
    for (int i = 6; i <= 9; i++) exp_q.push_back(i);
    drain_check("pp_drain");

    // Counter load and wrap
    wr(A_CYC, 32'hFFFF_FFFE);
    rd(A_CYC, rd_val); check("cyc_load", rd_val, 32'hFFFF_FFFE);
    tick();
    rd(A_CYC, rd_val); check("cyc_max", rd_val, 32'hFFFF_FFFF);
    tick();
    rd(A_CYC, rd_val); check("cyc_wrap", rd_val, 32'h0);

    // Asynchronous reset with entries queued
    for (int i = 0; i < 3; i++) wr(A_TX, 32'hA0 + i);
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_data", out_data, 32'h0);
    rd(A_STATUS, rd_val); check("arst_status", rd_val, 32'h02);
    rd(A_CYC, rd_val);    check("arst_cycles", rd_val, 32'h0);
    rd(32'd5, rd_val);    check("arst_ram5", rd_val, 32'hDEAD_BEEF);
    reset = 1'b0;
    tick();
    rd(A_STATUS, rd_val); check("post_rst_status", rd_val, 32'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the processor's dmem port: it answers every `address_dmem` / `wren` / `data` request and returns `q_dmem` in the same cycle, so the MW latch captures it at the edge that ends the M stage. It has three parts:
- a 4096-word RAM;
- a memory-mapped status register and 4-entry console transmit FIFO, drained through a valid/ready handshake;
- a free-running 32-bit cycle counter.

It is instantiated in the wrapper beside imem and the regfile.

## Interface
Parameters:
- `RAM_AW`, 12: RAM word-address width, giving 4096 words.
- `FIFO_DEPTH`, 4: TX FIFO entries. This is fixed at 4; the count field width depends on it.

Ports:
- `clock`  in  1: master clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high. Clears the FIFO, overflow flag and counter. RAM contents are not cleared.
- `address_dmem`  in  32: word address from the processor M stage.
- `data`  in  32: write data.
- `wren`  in  1: write enable, sampled at the rising edge.
- `q_dmem`  out  32: read data, combinational from `address_dmem`.
- `out_data`  out  32: FIFO head entry. 0 when empty.
- `out_valid`  out  1: high when the FIFO is non-empty.
- `out_ready`  in  1: consumer accepts the head this cycle.

## Operation
Memory map (word addresses, full 32-bit compare):

**RAM, `address_dmem[31:12] == 0`**
- Read: `q_dmem` = `ram[address_dmem[11:0]]`.
- Write: when `wren`, `ram[address_dmem[11:0]]` <= `data` at the edge.
- Contents are not defined after power-up.

**STATUS, `0x0000F000`**
- Read:
  - bit0 full (count==4)
  - bit1 empty (count==0)
  - bit2 overflow (sticky)
  - bits[5:3] count, 0..4
  - bits[31:6] read 0
- Write: any write clears overflow. `data` is ignored.

**TXDATA, `0x0000F001`**
- Write: pushes `data` into the FIFO tail.
- Read returns 0.
- A push while full with no pop that cycle is dropped, and overflow is set.

**CYCLES, `0x0000F002`**
- Read returns the current counter value.
- Write loads `data`. The counter then increments from the loaded value on the next edge.
- Otherwise the counter increments by 1 every edge and wraps `0xFFFFFFFF`->0.

**Any other address**
- Reads return 0; writes have no effect.

FIFO behaviour:
- Circular buffer: 2-bit head and tail pointers, 3-bit count.
- Pop occurs when `out_valid && out_ready` at the edge.
- Push accepted when count<4, or when count==4 and a pop occurs that same edge.
- Simultaneous push+pop leaves count unchanged; head and tail both advance.
- Push into an empty FIFO: the entry appears on `out_data` with `out_valid` high after that edge.
- There is no fall-through.

## Timing
Reset values:
- `out_valid`=0, `out_data`=0.
- count=0, head=tail=0, overflow=0, counter=0.
- `q_dmem` follows the address decode; reading STATUS during reset returns `0x00000002`.

Reset asserted mid-operation discards FIFO contents immediately (asynchronously). RAM is untouched.

Latency:
- Read: 0 cycles (combinational).
- Write: visible to a read of the same address on the cycle after the edge.
- A read and write to the same RAM address in one cycle returns the old data.

FIFO handshake: `out_data` / `out_valid` change only on rising edges or reset. A consumer holding `out_ready` high drains one entry per cycle.

Counter: increments on every edge, including cycles with dmem traffic; a CYCLES write overrides the increment. Reading CYCLES at cycle N after reset release returns N.

## Test plan
- **RAM:** write `0xDEADBEEF` to addr 5, then `0x12345678` to addr 4095 → reading addr 5 returns `0xDEADBEEF`, addr 4095 returns `0x12345678`, addr `0x1000` returns 0.
- **FIFO fill/overflow:** `out_ready`=0; push 1, 2, 3, 4, 5 → STATUS reads `0x25` (count 4, full, overflow); `out_data`=1. Write STATUS → reads `0x21`.
- **Drain:** `out_ready`=1 from a full FIFO → `out_data` 1, 2, 3, 4 on consecutive cycles; `out_valid` falls after the 4th pop; STATUS reads `0x02`.
- **Full + simultaneous push/pop:** full FIFO, push 9 while popping → accepted, no overflow, count stays 4, 9 emerges last.
- **Counter:** read CYCLES at cycle 10 after reset → 10. Write `0xFFFFFFFE` → reads `0xFFFFFFFF` one cycle later, then 0 the next.
- **Async reset:** assert reset for half a cycle with 3 entries queued → `out_valid` drops immediately, STATUS `0x02`, counter 0, RAM addr 5 still `0xDEADBEEF`.
